uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries; power of two, 4..256.
REQ-002 SHALL have parameter RTS_HI, default 12; rts_n_o rises when count_o reaches this value.
REQ-003 SHALL have parameter RTS_LO, default 4; rts_n_o falls when count_o drops to this value; RTS_LO < RTS_HI <= DEPTH.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_done_i  in  1  frame-complete level from the receiver; may stay high several cycles.
REQ-007 SHALL have port rx_data_i  in  32  received data, zero-extended; only [7:0] are stored.
REQ-008 SHALL have port parity_error_i  in  1  parity error of the current frame.
REQ-009 SHALL have port rd_en_i  in  1  pop request from the register block.
REQ-010 SHALL have port rd_data_o  out  8  head entry data, first-word-fall-through.
REQ-011 SHALL have port rd_parity_error_o  out  1  head entry parity flag.
REQ-012 SHALL have port empty_o  out  1  FIFO empty.
REQ-013 SHALL have port full_o  out  1  FIFO full.
REQ-014 SHALL have port count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overrun_o  out  1  sticky overrun flag.
REQ-016 SHALL have port overrun_clr_i  in  1  clears overrun_o.
REQ-017 SHALL have port rts_n_o  out  1  flow control to the peer; 1 = stop sending.

Function
REQ-018 SHALL register rx_done_i into rx_done_q; a push request SHALL be rx_done_i & ~rx_done_q, giving exactly one push per frame however long the level lasts.
REQ-019 SHALL write {parity_error_i, rx_data_i[7:0]} at the write pointer on the edge of a push when not full, then increment wr_ptr mod DEPTH.
REQ-020 SHALL pop on a clock edge with rd_en_i=1 and empty_o=0, incrementing rd_ptr mod DEPTH; rd_en_i while empty SHALL be ignored with no state change.
REQ-021 SHALL present the head entry on rd_data_o/rd_parity_error_o whenever empty_o=0; the outputs SHALL be 0 when empty.
REQ-022 SHALL make a pushed entry visible (empty_o=0, count_o updated) on the cycle after the push edge: one-cycle latency.
REQ-023 SHALL, on a simultaneous push and pop while neither full nor empty, perform both and leave count_o unchanged.
REQ-024 SHALL, on a simultaneous push and pop while full, perform both; the entry is accepted, count_o stays DEPTH, and overrun_o is not set.
REQ-025 SHALL, on a simultaneous push and pop while empty, accept the push and ignore the pop.
REQ-026 SHALL, on a push while full without a pop, drop the data, leave pointers unchanged, and set overrun_o.
REQ-027 SHALL clear overrun_o on overrun_clr_i; if a new overrun occurs on the same edge, set SHALL win.
REQ-028 SHALL derive full_o and empty_o from count_o: count_o == DEPTH and count_o == 0.
REQ-029 SHALL register rts_n_o with hysteresis: set when the next count >= RTS_HI, cleared when the next count <= RTS_LO, held otherwise.

Reset
REQ-030 SHALL, on rst=1, immediately clear the pointers, count_o, rx_done_q and overrun_o, force rts_n_o=0 and empty_o=1, and drive full_o=0 and the rd outputs to 0.
REQ-031 SHALL discard all stored entries on reset mid-operation; storage contents need not be reset.
REQ-032 SHALL, when rx_done_i is high while reset releases, load rx_done_q from it on the first edge without creating a push.

Configuration
REQ-033 SHALL, with UART_RX_FIFO_PERR_EN defined, store a 9-bit entry including the parity flag and drive rd_parity_error_o from it.
REQ-034 SHALL, without UART_RX_FIFO_PERR_EN, store 8-bit entries and tie rd_parity_error_o to 0; all other behaviour is identical.

Verification
REQ-035 SHALL cover: rx_done_i high 20 cycles with data 0x5A -> exactly one push; count_o=1; rd_data_o=0x5A one cycle after the edge.
REQ-036 SHALL cover: 17 pushes into DEPTH=16 with no reads -> full_o=1, overrun_o=1, the 17th byte dropped; 16 pops return the first 16 bytes in order, then empty_o=1.
REQ-037 SHALL cover: count 0 to 12 -> rts_n_o=1; pops down to 5 -> still 1; pop to 4 -> rts_n_o=0.
REQ-038 SHALL cover: full FIFO, push and pop on the same edge -> count_o=16, overrun_o=0, new byte last out; empty FIFO, push and pop -> count_o=1.
REQ-039 SHALL cover: rst pulse with 7 entries stored -> empty_o=1, count_o=0, rts_n_o=0 asynchronously; a later push of 0x33 reads back 0x33.
REQ-040 SHALL cover: with UART_RX_FIFO_PERR_EN, push 0x81 with parity_error_i=1 -> rd_parity_error_o=1; without the macro -> 0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - handshake/bus bundle between UART receiver, register block and RX FIFO
//
// Purpose: groups every non-clock, non-reset signal of uart_rx_fifo.
//   slave  modport : used by the FIFO itself
//   master modport : used by whatever drives the FIFO (receiver + register block)
// Signals:
//   rx_done_i         frame-complete level from the receiver
//   rx_data_i[31:0]   received data, zero-extended; only [7:0] are stored
//   parity_error_i    parity error of the current frame
//   rd_en_i           pop request
//   rd_data_o[7:0]    head entry data (first-word-fall-through, 0 when empty)
//   rd_parity_error_o head entry parity flag
//   empty_o / full_o  occupancy flags
//   count_o           occupancy 0..DEPTH
//   overrun_o         sticky overrun flag
//   overrun_clr_i     clears overrun_o
//   rts_n_o           flow control to the peer, 1 = stop sending
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_done_i;
  logic [31:0]   rx_data_i;
  logic          parity_error_i;
  logic          rd_en_i;
  logic [7:0]    rd_data_o;
  logic          rd_parity_error_o;
  logic          empty_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          overrun_o;
  logic          overrun_clr_i;
  logic          rts_n_o;

  modport slave (
    input  rx_done_i, rx_data_i, parity_error_i, rd_en_i, overrun_clr_i,
    output rd_data_o, rd_parity_error_o, empty_o, full_o, count_o, overrun_o, rts_n_o
  );

  modport master (
    output rx_done_i, rx_data_i, parity_error_i, rd_en_i, overrun_clr_i,
    input  rd_data_o, rd_parity_error_o, empty_o, full_o, count_o, overrun_o, rts_n_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with edge-detected push, sticky overrun and RTS hysteresis
//
// Purpose: buffers received bytes (optionally with their parity flag) between the
//   UART receiver and the register block. One push per rising edge of rx_done_i,
//   first-word-fall-through read side, registered RTS flow control.
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - uart_rx_fifo_if.slave (see interface file for signal list)
// Parameters:
//   DEPTH  - entries, power of two 4..256
//   RTS_HI - rts_n_o rises when the occupancy reaches this value
//   RTS_LO - rts_n_o falls when the occupancy drops to this value
// Configuration macro:
//   UART_RX_FIFO_PERR_EN - when defined, entries are 9 bits and carry the parity
//                          flag; otherwise 8 bits and rd_parity_error_o is 0.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_FIFO_PERR_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C    = CW'(RTS_HI);
  localparam logic [CW-1:0] LO_C    = CW'(RTS_LO);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_nxt;
  logic          rx_done_q;
  logic          armed_q;
  logic          overrun_q;
  logic          rts_q;
  logic          push_req, pop, wr_en, drop, empty, full;
  logic [EW-1:0] wr_entry, head;
  logic          unused_bits;

  // armed_q is low on the first edge after reset, so a rx_done_i level that is
  // already high at reset release only loads rx_done_q and never pushes.
  assign push_req  = bus.rx_done_i & ~rx_done_q & armed_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = bus.rd_en_i & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en     = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign count_nxt = count_q + CW'(wr_en) - CW'(pop);
  assign head      = mem[rd_ptr];

`ifdef UART_RX_FIFO_PERR_EN
  assign wr_entry              = {bus.parity_error_i, bus.rx_data_i[7:0]};
  assign bus.rd_parity_error_o = empty ? 1'b0 : head[8];
  assign unused_bits           = ^bus.rx_data_i[31:8];
`else
  assign wr_entry              = bus.rx_data_i[7:0];
  assign bus.rd_parity_error_o = 1'b0;
  assign unused_bits           = ^{bus.rx_data_i[31:8], bus.parity_error_i};
`endif

  assign bus.rd_data_o = empty ? 8'h00 : head[7:0];
  assign bus.empty_o   = empty;
  assign bus.full_o    = full;
  assign bus.count_o   = count_q;
  assign bus.overrun_o = overrun_q;
  assign bus.rts_n_o   = rts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rx_done_q <= 1'b0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
      rts_q     <= 1'b0;
    end else begin
      rx_done_q <= bus.rx_done_i;
      armed_q   <= 1'b1;
      count_q   <= count_nxt;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      // A new overrun on the same edge as a clear wins.
      if (drop)                   overrun_q <= 1'b1;
      else if (bus.overrun_clr_i) overrun_q <= 1'b0;
      if (count_nxt >= HI_C)      rts_q <= 1'b1;
      else if (count_nxt <= LO_C) rts_q <= 1'b0;
    end
  end

  // Storage is not reset; entries beyond the pointers are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue reference model
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int RTS_HI = 12;
  localparam int RTS_LO = 4;
`ifdef UART_RX_FIFO_PERR_EN
  localparam bit PERR_EN = 1'b1;
`else
  localparam bit PERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .RTS_HI(RTS_HI), .RTS_LO(RTS_LO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model: contents as a plain queue plus flags.
  logic [8:0] q[$];
  bit m_ovr, m_rts, m_prev, m_armed;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    q.delete();
    m_ovr = 1'b0; m_rts = 1'b0; m_prev = 1'b0; m_armed = 1'b0;
  endfunction

  // Effect of one rising clock edge, from the currently applied inputs.
  function automatic void model_edge();
    bit push, pop, was_full, lost;
    push     = m_armed && bus.rx_done_i && !m_prev;
    m_prev   = bus.rx_done_i;
    m_armed  = 1'b1;
    pop      = bus.rd_en_i && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    lost     = 1'b0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!was_full || pop) q.push_back({PERR_EN & bus.parity_error_i, bus.rx_data_i[7:0]});
      else lost = 1'b1;
    end
    if (lost) m_ovr = 1'b1;
    else if (bus.overrun_clr_i) m_ovr = 1'b0;
    if (q.size() >= RTS_HI) m_rts = 1'b1;
    else if (q.size() <= RTS_LO) m_rts = 1'b0;
  endfunction

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count",   int'(bus.count_o), q.size());
      chk("empty",   int'(bus.empty_o), int'(q.size() == 0));
      chk("full",    int'(bus.full_o),  int'(q.size() == DEPTH));
      chk("rd_data", int'(bus.rd_data_o), (q.size() > 0) ? int'(q[0][7:0]) : 0);
      chk("rd_perr", int'(bus.rd_parity_error_o), (q.size() > 0) ? int'(q[0][8]) : 0);
      chk("overrun", int'(bus.overrun_o), int'(m_ovr));
      chk("rts_n",   int'(bus.rts_n_o),   int'(m_rts));
    end
  end

  task automatic cyc(input bit rx, input logic [7:0] d, input bit pe, input bit rd, input bit clr);
    bus.rx_done_i      = rx;
    bus.rx_data_i      = {24'h0, d};
    bus.parity_error_i = pe;
    bus.rd_en_i        = rd;
    bus.overrun_clr_i  = clr;
    @(posedge clk);
    if (rst) model_clear();
    else model_edge();
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit pe);
    cyc(1'b1, d, pe, 1'b0, 1'b0);
    cyc(1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse between edges; rx_done_i is left high across
  // release so the first edge must not push.
  task automatic do_reset(input bit rx_hi);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_empty", int'(bus.empty_o), 1);
    chk("rst_count", int'(bus.count_o), 0);
    chk("rst_rts",   int'(bus.rts_n_o), 0);
    chk("rst_full",  int'(bus.full_o), 0);
    chk("rst_data",  int'(bus.rd_data_o), 0);
    chk("rst_ovr",   int'(bus.overrun_o), 0);
    bus.rx_done_i = rx_hi;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.rx_done_i = 1'b0; bus.rx_data_i = '0; bus.parity_error_i = 1'b0;
    bus.rd_en_i = 1'b0; bus.overrun_clr_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_empty", int'(bus.empty_o), 1);
    chk("init_count", int'(bus.count_o), 0);
    chk("init_rts",   int'(bus.rts_n_o), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Long rx_done level -> exactly one push, visible right after the edge.
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("lvl_count1", int'(bus.count_o), 1);
    chk("lvl_data",   int'(bus.rd_data_o), 8'h5A);
    repeat (19) cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("lvl_count20", int'(bus.count_o), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pop_one();
    chk("lvl_empty", int'(bus.empty_o), 1);

    // 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i), 1'b0);
    chk("ovf_full",  int'(bus.full_o), 1);
    chk("ovf_ovr",   int'(bus.overrun_o), 1);
    chk("ovf_count", int'(bus.count_o), 16);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_order", int'(bus.rd_data_o), 8'h10 + i);
      pop_one();
    end
    chk("ovf_empty", int'(bus.empty_o), 1);
    pop_one();
    chk("ovf_pop_empty", int'(bus.count_o), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", int'(bus.overrun_o), 0);

    // RTS hysteresis.
    for (int i = 0; i < 11; i++) push_byte(8'(i), 1'b0);
    chk("rts_11", int'(bus.rts_n_o), 0);
    push_byte(8'd11, 1'b0);
    chk("rts_12", int'(bus.rts_n_o), 1);
    repeat (7) pop_one();
    chk("rts_cnt5", int'(bus.count_o), 5);
    chk("rts_5", int'(bus.rts_n_o), 1);
    pop_one();
    chk("rts_4", int'(bus.rts_n_o), 0);
    repeat (4) pop_one();

    // Push and pop together while full, then while empty.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("fpp_count", int'(bus.count_o), 16);
    chk("fpp_ovr",   int'(bus.overrun_o), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("fpp_order", int'(bus.rd_data_o), (i == 15) ? 8'hEE : 8'h21 + i);
      pop_one();
    end
    cyc(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    chk("epp_count", int'(bus.count_o), 1);
    chk("epp_data",  int'(bus.rd_data_o), 8'h44);
    pop_one();

    // Reset with 7 entries stored; rx_done high through release.
    for (int i = 0; i < 7; i++) push_byte(8'(8'h60 + i), 1'b0);
    chk("pre_rst_count", int'(bus.count_o), 7);
    do_reset(1'b1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("rel_nopush", int'(bus.count_o), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push_byte(8'h33, 1'b0);
    chk("post_rst_data",  int'(bus.rd_data_o), 8'h33);
    chk("post_rst_count", int'(bus.count_o), 1);
    pop_one();

    // Parity flag.
    push_byte(8'h81, 1'b1);
    chk("perr_data", int'(bus.rd_data_o), 8'h81);
    chk("perr_flag", int'(bus.rd_parity_error_o), int'(PERR_EN));
    pop_one();

    // Randomized traffic with varying pop pressure and occasional resets.
    for (int ph = 0; ph < 16; ph++) begin
      int pop_pct;
      pop_pct = $urandom_range(5, 95);
      for (int c = 0; c < 200; c++) begin
        cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < pop_pct), ($urandom_range(0, 19) == 0));
      end
      if (ph % 5 == 4) do_reset(1'($urandom_range(0, 1)));
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
